// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings, default latencies and helpers for the multiply/divide unit.
// Division support is compiled only when MDU_DIV_EN is defined.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Counter must hold the larger of the two latencies.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(longest + 1);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for MULT/MULTU and, with MDU_DIV_EN,
// DIV/DIVU (truncating toward zero, remainder takes the dividend's sign).
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

`ifdef MDU_DIV_EN
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  // Signed division runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign a_neg   = (op == OP_DIV) && src_a[31];
  assign b_neg   = (op == OP_DIV) && src_b[31];
  assign mag_a   = a_neg ? (32'd0 - src_a) : src_a;
  assign mag_b   = b_neg ? (32'd0 - src_b) : src_b;
  assign quo_mag = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
  assign rem_mag = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
  assign quo_res = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_res = a_neg ? (32'd0 - rem_mag) : rem_mag;
`endif

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      OP_MULT:  {hi_res, lo_res} = prod_s;
      OP_MULTU: {hi_res, lo_res} = prod_u;
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        hi_res = rem_res;
        lo_res = quo_res;
      end
`endif
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: IDLE/BUSY FSM, latency counter, shadow and HI/LO regs.
// DIV/DIVU are honoured only when MDU_DIV_EN is defined; otherwise they are no-ops.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e  state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] sh_hi_reg, sh_hi_next;
  logic [31:0] sh_lo_reg, sh_lo_next;
  logic        sh_wr_reg, sh_wr_next;

  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        idle;
  logic        launch_mult;
  logic        launch_div;
  logic        launch;
  logic        finish;

  mdu_arith u_arith (
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  assign idle        = (state_reg == ST_IDLE);
  assign launch_mult = idle && start && is_mult_op(op);
`ifdef MDU_DIV_EN
  assign launch_div  = idle && start && is_div_op(op);
`else
  assign launch_div  = 1'b0;
`endif
  assign launch      = launch_mult || launch_div;
  assign finish      = (state_reg == ST_BUSY) && (cnt_reg == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      sh_hi_reg <= 32'd0;
      sh_lo_reg <= 32'd0;
      sh_wr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      sh_hi_reg <= sh_hi_next;
      sh_lo_reg <= sh_lo_next;
      sh_wr_reg <= sh_wr_next;
    end
  end

  // Next-state and counter; a start seen while BUSY is deliberately ignored.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (launch) begin
          state_next = ST_BUSY;
          cnt_next   = launch_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      ST_BUSY: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (finish) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Result is captured at launch and only committed on the last busy edge.
  always_comb begin
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    sh_hi_next = sh_hi_reg;
    sh_lo_next = sh_lo_reg;
    sh_wr_next = sh_wr_reg;
    if (launch) begin
      sh_hi_next = hi_res;
      sh_lo_next = lo_res;
      sh_wr_next = launch_mult || (src_b != 32'd0);
    end else if (finish) begin
      if (sh_wr_reg) begin
        hi_next = sh_hi_reg;
        lo_next = sh_lo_reg;
      end
    end else if (idle && start && (op == OP_MTHI)) begin
      hi_next = src_a;
    end else if (idle && start && (op == OP_MTLO)) begin
      lo_next = src_a;
    end
  end

  always_comb begin
    busy  = (state_reg == ST_BUSY);
    stall = use_d && ((state_reg == ST_BUSY) || start);
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a cycle-level reference model and literal checks.
// Expectations for DIV/DIVU follow whether MDU_DIV_EN is defined.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        use_d = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .use_d (use_d),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation launched at edge s is busy until edge s+N, commits then.
  int          e = 0;
  int          done_edge = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0;
  logic [31:0] p_lo = 32'd0;
  logic        p_wr = 1'b0;

  function automatic int model_cycles(input logic [2:0] o);
    if (o == OP_MULT || o == OP_MULTU) return MC;
`ifdef MDU_DIV_EN
    if (o == OP_DIV || o == OP_DIVU) return DC;
`endif
    return 0;
  endfunction

  function automatic logic [64:0] model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, rm;
    logic [63:0] ua, ub, pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      OP_MULT:  begin pr = sa * sb; return {1'b1, pr}; end
      OP_MULTU: begin pr = ua * ub; return {1'b1, pr}; end
      OP_DIV: begin
        if (b == 32'd0) return 65'd0;
        q  = sa / sb;
        rm = sa % sb;
        return {1'b1, rm[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return 65'd0;
        pr = ua / ub;
        q  = longint'(ua % ub);
        return {1'b1, q[31:0], pr[31:0]};
      end
      default: return 65'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    e <= e + 1;
    if (reset) begin
      m_hi      <= 32'd0;
      m_lo      <= 32'd0;
      p_wr      <= 1'b0;
      done_edge <= e + 1;
    end else begin
      if ((e + 1 == done_edge) && p_wr) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
      if (start && (e >= done_edge)) begin
        if (model_cycles(op) > 0) begin
          done_edge <= e + 1 + model_cycles(op);
          {p_wr, p_hi, p_lo} <= model_op(op, src_a, src_b);
        end else if (op == OP_MTHI) begin
          m_hi <= src_a;
        end else if (op == OP_MTLO) begin
          m_lo <= src_a;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (e > 0) begin
      check("m_busy",  32'(busy),  32'(e < done_edge));
      check("m_stall", 32'(stall), 32'(use_d & ((e < done_edge) | start)));
      check("m_hi", hi, m_hi);
      check("m_lo", lo, m_lo);
    end
  end

  // Issues one start pulse and returns the number of cycles busy was seen high.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int bcyc);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    bcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      else break;
    end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
    $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", o, a, b, bcyc, hi, lo);
  endtask

  int bc;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, bc);
    check("mult_busy", bc, 5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    issue(OP_MTHI, 32'h00001234, 32'd0, bc);
    check("mthi_busy", bc, 0);
    check("mthi_hi", hi, 32'h00001234);
    issue(OP_MTLO, 32'h00005678, 32'd0, bc);
    check("mtlo_lo", lo, 32'h00005678);

`ifdef MDU_DIV_EN
    issue(OP_DIVU, 32'd100, 32'd7, bc);
    check("divu_busy", bc, 10);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, bc);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, bc);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h00000000);
    issue(OP_DIV, 32'd55, 32'd0, bc);
    check("div0_busy", bc, 10);
    check("div0_lo", lo, 32'h80000000);
    check("div0_hi", hi, 32'h00000000);
`else
    issue(OP_DIVU, 32'd100, 32'd7, bc);
    check("nodiv_busy", bc, 0);
    check("nodiv_hi", hi, 32'h00001234);
    check("nodiv_lo", lo, 32'h00005678);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, bc);
    check("nodiv2_busy", bc, 0);
    check("nodiv2_lo", lo, 32'h00005678);
`endif

    issue(3'd6, 32'hAAAA5555, 32'h12345678, bc);
    check("undef_busy", bc, 0);
    issue(3'd7, 32'h0BADF00D, 32'h1, bc);
    check("undef_busy7", bc, 0);

    // Stall from the start cycle through the final busy cycle.
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd6; use_d = 1'b1;
    @(negedge clk);
    check("stall_start", 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      check("stall_busy", 32'(stall), 32'd1);
    end
    check("stall_after", 32'(stall), 32'd0);
    check("stall_lo", lo, 32'd42);
    $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h use_d=1", OP_MULT, 32'd7, 32'd6, bc, hi, lo);
    use_d = 1'b0;

    // A start arriving while busy must not disturb anything.
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULT; src_a = 32'h00010000; src_b = 32'h00010000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = OP_MTHI; src_a = 32'h0000BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("ign_hi", hi, 32'd0);
    repeat (5) @(negedge clk);
    check("ign_done_hi", hi, 32'd1);
    check("ign_done_lo", lo, 32'd0);
    $display("op=%0d a=%h b=%h with MTHI during busy hi=%h lo=%h", OP_MULT, 32'h00010000, 32'h00010000, hi, lo);

    // Reset during busy cycle 3 aborts without commit.
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_hi", hi, 32'd0);
    $display("op=%0d a=%h b=%h aborted by reset hi=%h lo=%h", OP_MULT, 32'd3, 32'd5, hi, lo);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
